// File: rtl/hk_spi_wr_sequencer.sv
// Posts housekeeping SPI register writes into a small FIFO and drains them onto the shared
// register bus via req/gnt/ack, forwarding undrained data to SPI readback.
module hk_spi_wr_sequencer #(
  parameter int FIFO_DEPTH  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       SCK,
  input  logic       csb_reset,
  input  logic [7:0] spi_addr,
  input  logic [7:0] spi_wdata,
  input  logic       spi_wrstb,
  output logic [7:0] spi_idata,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       bus_stb,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_ack,
  output logic       busy,
  output logic       wr_overflow,
  output logic       bus_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_stb_q, bus_stb_d;
  logic        wr_overflow_q, wr_overflow_d;
  logic        bus_timeout_q, bus_timeout_d;

  logic [7:0]  fifo_addr_q [FIFO_DEPTH];
  logic [7:0]  fifo_data_q [FIFO_DEPTH];

  logic [AW-1:0] head_idx;
  logic [AW-1:0] fwd_idx;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          fwd_hit;
  logic [7:0]    fwd_data;

  assign head_idx = rd_ptr_q[AW-1:0];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  // A pop on the same edge never makes room for a push: fullness is judged on current pointers.
  assign push     = spi_wrstb && !full;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    bus_timeout_d = bus_timeout_q;
    wr_overflow_d = wr_overflow_q | (spi_wrstb & full);
    case (state_q)
      REQ: begin
        if (bus_gnt) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack) begin
          pop = 1'b1;
        end else if (cnt_d == 8'(ACK_TIMEOUT)) begin
          pop           = 1'b1;
          bus_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    // Leaving IDLE looks at the post-push occupancy so the request rises with the head entry.
    if (state_q == IDLE || pop) begin
      state_d = (wr_ptr_d != rd_ptr_d) ? REQ : IDLE;
    end
    bus_req_d = (state_d != IDLE);
    bus_stb_d = (state_d == ACCESS);
  end

  always_ff @(posedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_stb_q     <= 1'b0;
      wr_overflow_q <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_stb_q     <= bus_stb_d;
      wr_overflow_q <= wr_overflow_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  always_ff @(posedge SCK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[AW-1:0]] <= spi_addr;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= spi_wdata;
    end
  end

  // Walk oldest to newest so the last match (newest posted write) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    fwd_idx  = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwd_idx = head_idx + AW'(k);
      if (((AW+1)'(k) < count) && (fifo_addr_q[fwd_idx] == spi_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data_q[fwd_idx];
      end
    end
  end

  assign spi_idata   = fwd_hit ? fwd_data : rd_data;
  assign rd_addr     = spi_addr;
  assign bus_addr    = empty ? 8'h00 : fifo_addr_q[head_idx];
  assign bus_wdata   = empty ? 8'h00 : fifo_data_q[head_idx];
  assign bus_req     = bus_req_q;
  assign bus_stb     = bus_stb_q;
  assign busy        = !empty || (state_q != IDLE);
  assign wr_overflow = wr_overflow_q;
  assign bus_timeout = bus_timeout_q;

endmodule
